// File: rtl/mips_avalon_mem_bank_pkg.sv
// Shared types for the Avalon memory bank model.
// Holds the response and FSM state encodings plus the small sizing helpers.
package mips_avalon_pkg;

  typedef enum logic [1:0] {
    OKAY        = 2'b00,
    SLAVEERROR  = 2'b10,
    DECODEERROR = 2'b11
  } avalon_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } mem_state_t;

  // Sized for the largest DELAY plus the 0-3 stall cycles.
  localparam int CNT_W = 8;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mips_avalon_mem_bank_if.sv
// Avalon-MM request/response bundle between the CPU master and the memory bank.
interface mips_avalon_mem_bank_if #(
  parameter int DATA_W = 32
);
  logic [31:0]         address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic [1:0]          response;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, response
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, response
  );
endinterface

// File: rtl/mips_avalon_stall_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) giving 0-3 extra wait cycles.
// Steps once per accepted request; extra reflects the value before stepping.
module mips_avalon_stall_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       advance,
  output logic [1:0] extra
);

  logic [15:0] lfsr_q, lfsr_d;
  logic        fb;

  assign fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign extra = lfsr_q[1:0];

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) lfsr_d = {lfsr_q[14:0], fb};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/mips_avalon_mem_bank.sv
// Avalon-MM slave memory with instruction and data regions, per-op latency and error responses.
// Optional pseudo-random extra wait states when MIPS_AVALON_RAND_STALL_EN is defined.
module mips_avalon_mem_bank
  import mips_avalon_pkg::*;
#(
  parameter int          DATA_W          = 32,
  parameter logic [31:0] INSTR_BASE      = 32'hBFC00000,
  parameter int          INSTR_WORDS     = 1024,
  parameter logic [31:0] DATA_BASE       = 32'h00000000,
  parameter int          DATA_WORDS      = 1024,
  parameter int          READ_DELAY      = 2,
  parameter int          WRITE_DELAY     = 2,
  parameter int          INSTR_WRITABLE  = 0,
  parameter string       INSTR_INIT_FILE = "",
  parameter string       DATA_INIT_FILE  = "",
  parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  mips_avalon_mem_bank_if.slave  bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IW    = clog2_min1(INSTR_WORDS);
  localparam int DW    = clog2_min1(DATA_WORDS);

  logic [DATA_W-1:0] imem [INSTR_WORDS];
  logic [DATA_W-1:0] dmem [DATA_WORDS];

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, delay;
  logic [31:0]       addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BYTES-1:0]  be_q;
  avalon_resp_t      err_q, err_in;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  avalon_resp_t      resp_q, resp_d;
  logic              req, from_idle, latch_en, do_op;

  // A DELAY of 1 enters ACK on the sampling edge, before the latches hold the request.
  logic [31:0]       cur_addr, ioff, doff;
  logic              cur_wr, in_i, in_d;
  logic [DATA_W-1:0] cur_wdata;
  logic [BYTES-1:0]  cur_be;
  avalon_resp_t      cur_err;
  logic [IW-1:0]     iidx;
  logic [DW-1:0]     didx;

  assign req       = bus.read | bus.write;
  assign from_idle = (state_q == IDLE);
  assign cur_addr  = from_idle ? bus.address    : addr_q;
  assign cur_wr    = from_idle ? bus.write      : wr_q;
  assign cur_wdata = from_idle ? bus.writedata  : wdata_q;
  assign cur_be    = from_idle ? bus.byteenable : be_q;
  assign cur_err   = from_idle ? err_in         : err_q;

  assign ioff = cur_addr - INSTR_BASE;
  assign doff = cur_addr - DATA_BASE;
  assign in_i = (cur_addr >= INSTR_BASE) && (ioff < 32'(INSTR_WORDS * BYTES));
  assign in_d = (cur_addr >= DATA_BASE)  && (doff < 32'(DATA_WORDS * BYTES));
  assign iidx = IW'(ioff >> OFF_W);
  assign didx = DW'(doff >> OFF_W);

  always_comb begin
    err_in = OKAY;
    if ((bus.address & 32'(BYTES - 1)) != 32'd0) err_in = SLAVEERROR;
    else if (bus.read && bus.write)               err_in = SLAVEERROR;
    else if (!in_i && !in_d)                      err_in = DECODEERROR;
    else if (bus.write && in_i && INSTR_WRITABLE == 0) err_in = SLAVEERROR;
  end

`ifdef MIPS_AVALON_RAND_STALL_EN
  logic [1:0] extra;

  mips_avalon_stall_lfsr #(.SEED(STALL_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (latch_en),
    .extra   (extra)
  );

  assign delay = (bus.write ? CNT_W'(WRITE_DELAY) : CNT_W'(READ_DELAY)) + CNT_W'(extra);
`else
  assign delay = bus.write ? CNT_W'(WRITE_DELAY) : CNT_W'(READ_DELAY);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    do_op    = 1'b0;
    unique case (state_q)
      IDLE: if (req) begin
        latch_en = 1'b1;
        cnt_d    = delay - CNT_W'(1);
        if (delay == CNT_W'(1)) begin
          state_d = ACK;
          do_op   = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: if (!req) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ACK;
          do_op   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    resp_d  = resp_q;
    if (do_op) begin
      resp_d = cur_err;
      if (cur_err != OKAY) rdata_d = '0;
      else if (!cur_wr)    rdata_d = in_i ? imem[iidx] : dmem[didx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      resp_q  <= OKAY;
      err_q   <= OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      if (latch_en) err_q <= err_in;
    end
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      addr_q  <= bus.address;
      wr_q    <= bus.write;
      wdata_q <= bus.writedata;
      be_q    <= bus.byteenable;
    end
  end

  // Reset on the ACK-entry edge drops the write.
  always_ff @(posedge clk) begin
    if (reset_n && do_op && cur_wr && cur_err == OKAY) begin
      for (int b = 0; b < BYTES; b++) begin
        if (cur_be[b]) begin
          if (in_i) imem[iidx][b*8 +: 8] <= cur_wdata[b*8 +: 8];
          else      dmem[didx][b*8 +: 8] <= cur_wdata[b*8 +: 8];
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < INSTR_WORDS; i++) imem[i] = '0;
    for (int i = 0; i < DATA_WORDS; i++)  dmem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset_n && state_q == WAIT) begin
      assert (req) else $error("mips_avalon_mem_bank: request dropped during waitrequest");
      assert (!req || bus.address == addr_q)
        else $error("mips_avalon_mem_bank: address changed during waitrequest");
    end
  end

  assign bus.waitrequest = req && (state_q != ACK);
  assign bus.readdata    = rdata_q;
  assign bus.response    = resp_q;

endmodule

// File: tb/tb_mips_avalon_mem_bank.sv
// Directed bench for mips_avalon_mem_bank across three configurations with a response scoreboard.
module tb_mips_avalon_mem_bank;

  localparam int A = 0;  // 32-bit, R2/W2, instruction region writable
  localparam int B = 1;  // 32-bit, R2/W4, instruction region read-only
  localparam int C = 2;  // 64-bit, R2/W1
`ifdef MIPS_AVALON_RAND_STALL_EN
  localparam int SLACK = 3;
`else
  localparam int SLACK = 0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mips_avalon_mem_bank_if #(.DATA_W(32)) if_a ();
  mips_avalon_mem_bank_if #(.DATA_W(32)) if_b ();
  mips_avalon_mem_bank_if #(.DATA_W(64)) if_c ();

  mips_avalon_mem_bank #(.DATA_W(32), .READ_DELAY(2), .WRITE_DELAY(2), .INSTR_WRITABLE(1))
    u_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
  mips_avalon_mem_bank #(.DATA_W(32), .READ_DELAY(2), .WRITE_DELAY(4), .INSTR_WRITABLE(0))
    u_b (.clk(clk), .reset_n(reset_n), .bus(if_b));
  mips_avalon_mem_bank #(.DATA_W(64), .READ_DELAY(2), .WRITE_DELAY(1))
    u_c (.clk(clk), .reset_n(reset_n), .bus(if_c));

  typedef struct {
    logic [63:0] rd;
    logic [1:0]  resp;
    int          wmin;
    int          wmax;
    bit          chk_rd;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          sel      = A;
  logic        cur_wait;
  logic [63:0] cur_rd;
  logic [1:0]  cur_resp;
  logic [31:0] model [8];

  always_comb begin
    cur_wait = 1'b0;
    cur_rd   = '0;
    cur_resp = '0;
    case (sel)
      A: begin cur_wait = if_a.waitrequest; cur_rd = {32'h0, if_a.readdata}; cur_resp = if_a.response; end
      B: begin cur_wait = if_b.waitrequest; cur_rd = {32'h0, if_b.readdata}; cur_resp = if_b.response; end
      default: begin cur_wait = if_c.waitrequest; cur_rd = if_c.readdata; cur_resp = if_c.response; end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    if_a.read = 0; if_a.write = 0; if_a.address = '0; if_a.writedata = '0; if_a.byteenable = '0;
    if_b.read = 0; if_b.write = 0; if_b.address = '0; if_b.writedata = '0; if_b.byteenable = '0;
    if_c.read = 0; if_c.write = 0; if_c.address = '0; if_c.writedata = '0; if_c.byteenable = '0;
  endtask

  task automatic drive(input int d, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [7:0] be);
    case (d)
      A: begin if_a.read = rd; if_a.write = wr; if_a.address = addr;
               if_a.writedata = wd[31:0]; if_a.byteenable = be[3:0]; end
      B: begin if_b.read = rd; if_b.write = wr; if_b.address = addr;
               if_b.writedata = wd[31:0]; if_b.byteenable = be[3:0]; end
      default: begin if_c.read = rd; if_c.write = wr; if_c.address = addr;
               if_c.writedata = wd; if_c.byteenable = be; end
    endcase
  endtask

  // Starts #1 after a rising edge, ends #1 after the completing edge.
  task automatic xfer(input int d, input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [63:0] wd, input logic [7:0] be, input logic [63:0] exp_rd,
                      input logic [1:0] exp_resp, input int dly, input bit chk_rd, input string tag);
    exp_t e;
    int   waits;
    bit   done;
    e.rd = exp_rd; e.resp = exp_resp; e.wmin = dly; e.wmax = dly + SLACK; e.chk_rd = chk_rd;
    sb.push_back(e);
    sel = d;
    drive(d, rd, wr, addr, wd, be);
    waits = 0;
    done  = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (cur_wait) waits++;
      else          done = 1;
    end
    e = sb.pop_front();
    chk({tag, "_done"}, 64'(done), 64'd1);
    if (done) begin
      n_assert++;
      assert (waits >= e.wmin && waits <= e.wmax) else begin
        n_fail++;
        $error("FAIL %s_wait: observed %0d expected %0d..%0d", tag, waits, e.wmin, e.wmax);
      end
      chk({tag, "_resp"}, 64'(cur_resp), 64'(e.resp));
      if (e.chk_rd) chk({tag, "_rdata"}, cur_rd, e.rd);
    end
    @(posedge clk);
    #1;
    idle_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    reset_n = 1'b0;
    idle_all();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata_a", 64'(if_a.readdata), 64'h0);
    chk("rst_resp_b", 64'(if_b.response), 64'h0);
    chk("rst_rdata_c", if_c.readdata, 64'h0);
    chk("rst_wait_a", 64'(if_a.waitrequest), 64'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Instruction fetch from the boot vector
    xfer(A, 0, 1, 32'hBFC00000, 64'h3C011234, 8'hF, 64'h0, 2'b00, 2, 0, "iwr");
    xfer(A, 1, 0, 32'hBFC00000, 64'h0, 8'h0, 64'h3C011234, 2'b00, 2, 1, "ifetch");

    // Byte-enable merge
    xfer(A, 0, 1, 32'h8, 64'h11223344, 8'hF, 64'h0, 2'b00, 2, 0, "dwr_full");
    xfer(A, 0, 1, 32'h8, 64'hAABBCCDD, 8'h5, 64'h0, 2'b00, 2, 0, "dwr_be");
    xfer(A, 1, 0, 32'h8, 64'h0, 8'h0, 64'h11BB33DD, 2'b00, 2, 1, "drd_be");

    // Error classes on the read-only-instruction instance
    xfer(B, 0, 1, 32'h20, 64'hCAFEF00D, 8'hF, 64'h0, 2'b00, 4, 0, "b_wr");
    xfer(B, 1, 0, 32'h20, 64'h0, 8'h0, 64'hCAFEF00D, 2'b00, 2, 1, "b_rd");
    xfer(B, 1, 0, 32'h2, 64'h0, 8'h0, 64'h0, 2'b10, 2, 1, "misalign");
    xfer(B, 1, 0, 32'h20, 64'h0, 8'h0, 64'hCAFEF00D, 2'b00, 2, 1, "b_rd2");
    xfer(B, 1, 0, 32'h50000000, 64'h0, 8'h0, 64'h0, 2'b11, 2, 1, "decode");
    xfer(B, 0, 1, 32'hBFC00004, 64'hDEADBEEF, 8'hF, 64'h0, 2'b10, 4, 1, "ro_wr");
    xfer(B, 1, 0, 32'hBFC00004, 64'h0, 8'h0, 64'h0, 2'b00, 2, 1, "ro_chk");
    xfer(B, 1, 1, 32'h20, 64'h55555555, 8'hF, 64'h0, 2'b10, 4, 1, "rdwr");
    xfer(B, 1, 0, 32'h20, 64'h0, 8'h0, 64'hCAFEF00D, 2'b00, 2, 1, "rdwr_chk");

    // Reset while a write is waiting
    sel = B;
    drive(B, 0, 1, 32'h20, 64'h12345678, 8'hF);
    @(posedge clk);
    #1;
    chk("rstw_wait", 64'(if_b.waitrequest), 64'h1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    idle_all();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rstw_rdata", 64'(if_b.readdata), 64'h0);
    chk("rstw_resp", 64'(if_b.response), 64'h0);
    @(posedge clk);
    #1;
    xfer(B, 1, 0, 32'h20, 64'h0, 8'h0, 64'hCAFEF00D, 2'b00, 2, 1, "rstw_old");

    // 64-bit lanes with single-cycle writes
    xfer(C, 0, 1, 32'h10, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 2'b00, 1, 0, "c_wr");
    xfer(C, 1, 0, 32'h10, 64'h0, 8'h0, 64'h0123456789ABCDEF, 2'b00, 2, 1, "c_rd");
    xfer(C, 0, 1, 32'h18, 64'h1111111122222222, 8'hFF, 64'h0, 2'b00, 1, 0, "c_wr2");
    xfer(C, 0, 1, 32'h18, 64'hAAAAAAAABBBBBBBB, 8'h0F, 64'h0, 2'b00, 1, 0, "c_wr_be");
    xfer(C, 1, 0, 32'h18, 64'h0, 8'h0, 64'h11111111BBBBBBBB, 2'b00, 2, 1, "c_rd_be");
    xfer(C, 1, 0, 32'h14, 64'h0, 8'h0, 64'h0, 2'b10, 2, 1, "c_misalign");

    // Randomised reads against a preloaded model
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      xfer(A, 0, 1, 32'h100 + 32'(4 * i), 64'(model[i]), 8'hF, 64'h0, 2'b00, 2, 0, "pre");
    end
    for (int n = 0; n < 100; n++) begin
      k = $urandom_range(0, 7);
      xfer(A, 1, 0, 32'h100 + 32'(4 * k), 64'h0, 8'h0, 64'(model[k]), 2'b00, 2, 1, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
